// File: rtl/sleft_seq.sv
// sleft_seq - sequential 32-bit left shifter (one bit per clock).
//
// Shift-left counterpart of the one-bit-per-cycle right shifter used by the
// R-type datapath (sll/sllv). A request is captured when start=1 in IDLE or
// DONE. The operand then shifts left by one bit per clock, with zero-fill,
// until shamt bits have been shifted. The result is presented with a
// one-cycle done pulse.
//
// Optional feature macro: SLEFT_OVF_EN
//   defined   -> ovf is a sticky signed-overflow flag (the sign bit changed
//                on some shift step of the current request)
//   undefined -> ovf is tied to 0 and no overflow logic exists
//
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   start  in  1   request strobe (ignored while shifting)
//   A      in  32  operand, captured on the accepting edge
//   shamt  in  5   shift amount 0..31, captured on the accepting edge
//   out    out 32  registered result, held in IDLE/DONE
//   busy   out 1   state == SHIFT
//   done   out 1   state == DONE (one-cycle pulse)
//   cout   out 1   last bit shifted out of bit 31 (0 when shamt == 0)
//   ovf    out 1   sticky signed overflow (0 unless SLEFT_OVF_EN)

module sleft_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  shamt,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        busy_s;
    logic        done_s;
    logic [31:0] out_r;
    logic [4:0]  cnt_r;
    logic        cout_r;

    // A new request is taken only from IDLE or DONE; SHIFT ignores start.
    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_s = (shamt != 5'd0) ? SHIFT : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // cnt_r holds the number of shifts still to do, including this edge.
                if (cnt_r == 5'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            SHIFT:   busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= 32'd0;
            cnt_r  <= 5'd0;
            cout_r <= 1'b0;
        end else if (accept_s) begin
            out_r  <= A;
            cnt_r  <= shamt;
            cout_r <= 1'b0;
        end else if (state_r == SHIFT) begin
            out_r  <= {out_r[30:0], 1'b0};
            cout_r <= out_r[31];
            cnt_r  <= cnt_r - 5'd1;
        end else begin
            out_r  <= out_r;
            cnt_r  <= cnt_r;
            cout_r <= cout_r;
        end
    end

`ifdef SLEFT_OVF_EN
    logic ovf_r;

    // Sticky overflow: the sign bit changes when bits 31 and 30 differ before a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if ((state_r == SHIFT) && (out_r[31] != out_r[30])) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign out  = out_r;
    assign cout = cout_r;
    assign busy = busy_s;
    assign done = done_s;

endmodule

// File: doc/sleft_seq.md
# sleft_seq

Sequential left shifter for the R-type datapath; the shift-left counterpart to the existing one-bit right shifter. It takes a 32-bit operand and a 5-bit shift amount, shifts left one bit per clock, and returns the result with a one-cycle done pulse. The ALU control issues it for `sll`/`sllv`; the result register holds the value until the next accepted request.

## Interface
Parameters:
- none (width fixed at 32, shift amount fixed at 5 bits)

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: request strobe, sampled on `clk` rising edge
- `A` in 32: operand, captured when `start` is accepted
- `shamt` in 5: shift amount 0..31, captured when `start` is accepted
- `out` out 32: registered result
- `busy` out 1: high while shifting is in progress
- `done` out 1: one-cycle pulse when `out` is final
- `cout` out 1: last bit shifted out of bit 31; 0 when `shamt`=0
- `ovf` out 1: sticky signed-overflow flag; present only when `SLEFT_OVF_EN` is defined, otherwise tied to 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- A request is accepted when `start`=1 in IDLE or DONE. On the accepting edge:
  - `out` is loaded with `A`.
  - The internal count is loaded with `shamt`.
  - `cout` and `ovf` are cleared.
  - Next state is SHIFT if `shamt`≠0, otherwise DONE.
- Each SHIFT edge:
  - `out` becomes `out[30:0]` with 0 appended at bit 0.
  - `cout` takes the old `out[31]`.
  - The count decrements.
  - When the count equals 1, the next state is DONE.
- DONE lasts exactly one cycle. Without a new `start`, the next state is IDLE. With `start`=1 in DONE, the request is accepted (back-to-back operation).
- `start` is ignored during SHIFT; `A` and `shamt` do not matter there.
- Zero-fill only. There is no arithmetic variant, because left shift is the same for signed and unsigned operands.
- Shift amounts are always in range, since 5 bits cannot exceed 31. There is no wrap-around case.
- `out`, `cout` and `ovf` hold their values in IDLE and DONE.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, `cout`=0, `ovf`=0, state=IDLE.
- Reset asserted mid-operation aborts the shift immediately. No `done` is produced for the aborted request.
- `busy` = (state==SHIFT). `done` = (state==DONE). Both are decoded from registered state.
- Latency, counting the accepting edge as edge 0:
  - `done` is high for the cycle following edge `shamt`.
  - `shamt`=0 gives `done` in the cycle immediately after the accepting edge.
  - `shamt`=31 gives 32 cycles from start to done, including the done cycle.
- Throughput: one request per `shamt`+1 cycles with back-to-back starts issued in DONE.
- `out` is stable and valid in the cycle where `done`=1 and stays so until the next accepting edge.

## Configuration
- `SLEFT_OVF_EN` defined:
  - On each SHIFT edge, `ovf` is set if the old `out[31]` ≠ old `out[30]`, i.e. the sign bit changed.
  - `ovf` is sticky until the next accepting edge or reset.
  - `ovf` is valid with `done`.
- `SLEFT_OVF_EN` undefined:
  - `ovf` is driven constant 0.
  - No overflow logic is synthesized.
  - All other behaviour is identical.

## Test plan
- Single-bit walk: reset, then `A`=0x0000_0001, `shamt`=31.
  - `busy` high for 31 cycles.
  - `done` in the cycle after edge 31.
  - `out`=0x8000_0000, `cout`=0.
- Carry out: `A`=0xFFFF_FFFF, `shamt`=4 → `out`=0xFFFF_FFF0, `cout`=1, `done` after edge 4.
- Zero shift: `A`=0x1234_5678, `shamt`=0.
  - `busy` never high.
  - `done` in the cycle after the accepting edge.
  - `out`=0x1234_5678, `cout`=0.
- Busy ignore and back-to-back:
  - `A`=0x0000_00FF, `shamt`=8. Pulse `start` with `A`=0xDEAD_BEEF during SHIFT.
  - Result is `out`=0x0000_FF00; the mid-shift request is dropped.
  - Then hold `start` in DONE with `A`=0x1, `shamt`=1 → next `done` gives `out`=0x2.
- Reset mid-shift: `A`=0x8000_0001, `shamt`=10, drop `rst_n` after edge 3.
  - All outputs are 0 immediately and asynchronously.
  - No `done` pulse follows.
  - Release `rst_n` → IDLE.
- Overflow: `A`=0x4000_0000, `shamt`=1 → `out`=0x8000_0000.
  - With `SLEFT_OVF_EN`: `ovf`=1.
  - Without it: `ovf`=0.
  - `A`=0x0000_0003, `shamt`=2 → `ovf`=0 in both builds.
